// File: rtl/sigmoid_bwd.sv
// Backward pass of the sigmoid activation: grad_in = grad_out * y * (1 - y).
// Three-stage valid/ready pipeline with frame tracking and per-frame sample count.
module sigmoid_bwd #(
   parameter int DATA_WIDTH = 8,
   parameter int Y_FRAC     = 6,
   parameter int CNT_WIDTH  = 10
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DATA_WIDTH-1:0] in_y,
   input  logic [DATA_WIDTH-1:0] in_grad,
   input  logic                  in_last,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] out_grad,
   output logic                  out_last,
   output logic                  frame_done,
   output logic [CNT_WIDTH-1:0]  frame_len
);

   localparam int YW   = Y_FRAC + 1;
   localparam int DW_D = 2 * YW;
   localparam int PW   = DATA_WIDTH + 2 * Y_FRAC + 3;
   localparam int SH   = 2 * Y_FRAC;

   localparam logic [YW-1:0]         ONE    = YW'(1) << Y_FRAC;
   localparam logic [DATA_WIDTH-1:0] ONE_IN = DATA_WIDTH'(1) << Y_FRAC;
   localparam logic signed [PW-1:0]  ROUND  = PW'(1) << (SH - 1);

   logic en1, en2, en3;
   logic v1, v2, v3;

   logic [YW-1:0]         y1;
   logic [DATA_WIDTH-1:0] g1;
   logic                  l1;

   logic [DW_D-1:0]       d2;
   logic [DATA_WIDTH-1:0] g2;
   logic                  l2;

   logic [YW-1:0]         y_clamp;
   logic [DW_D-1:0]       d_comb;
   logic signed [PW-1:0]  p_round;

   logic [CNT_WIDTH-1:0]  cnt;
   logic                  xfer;

   // A stage may load when it is empty or the stage ahead is moving, so bubbles collapse.
   assign en3      = !v3 || out_ready;
   assign en2      = !v2 || en3;
   assign en1      = !v1 || en2;
   assign in_ready = en1;

   assign out_valid = v3;
   assign xfer      = v3 && out_ready;

   always_comb begin
      y_clamp = (in_y > ONE_IN) ? ONE : in_y[YW-1:0];
      d_comb  = DW_D'(y1) * DW_D'(ONE - y1);
      // d is at most 0.25, so the signed product can never leave DATA_WIDTH after scaling.
      p_round = $signed({{(PW-DATA_WIDTH){g2[DATA_WIDTH-1]}}, g2})
              * $signed({{(PW-DW_D){1'b0}}, d2}) + ROUND;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v1 <= 1'b0;
         y1 <= '0;
         g1 <= '0;
         l1 <= 1'b0;
      end else if (en1) begin
         v1 <= in_valid;
         y1 <= y_clamp;
         g1 <= in_grad;
         l1 <= in_last;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v2 <= 1'b0;
         d2 <= '0;
         g2 <= '0;
         l2 <= 1'b0;
      end else if (en2) begin
         v2 <= v1;
         d2 <= d_comb;
         g2 <= g1;
         l2 <= l1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v3       <= 1'b0;
         out_grad <= '0;
         out_last <= 1'b0;
      end else if (en3) begin
         v3       <= v2;
         out_grad <= DATA_WIDTH'(p_round >>> SH);
         out_last <= l2;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt        <= '0;
         frame_len  <= '0;
         frame_done <= 1'b0;
      end else begin
         frame_done <= xfer && out_last;
         if (xfer) begin
            if (out_last) begin
               frame_len <= cnt + CNT_WIDTH'(1);
               cnt       <= '0;
            end else begin
               cnt <= cnt + CNT_WIDTH'(1);
            end
         end
      end
   end

endmodule

// File: tb/tb_sigmoid_bwd.sv
// Self-checking bench for sigmoid_bwd: directed and randomized samples against
// an arithmetic reference of grad * y * (1 - y) with occupancy-based flow checks.
module tb_sigmoid_bwd;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       in_valid = 1'b0;
   logic       in_ready;
   logic [7:0] in_y = '0;
   logic [7:0] in_grad = '0;
   logic       in_last = 1'b0;
   logic       out_valid;
   logic       out_ready = 1'b0;
   logic [7:0] out_grad;
   logic       out_last;
   logic       frame_done;
   logic [9:0] frame_len;

   always #5 clk = ~clk;

   sigmoid_bwd #(.DATA_WIDTH(8), .Y_FRAC(6), .CNT_WIDTH(10)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_y(in_y), .in_grad(in_grad), .in_last(in_last),
      .out_valid(out_valid), .out_ready(out_ready), .out_grad(out_grad), .out_last(out_last),
      .frame_done(frame_done), .frame_len(frame_len)
   );

   typedef struct {
      logic [7:0] g;
      logic       l;
      int         e;
   } item_t;

   item_t      exp_q[$];
   int         n_vec = 0;
   int         n_err = 0;
   int         edge_n = 0;
   int         fd_seen = 0;
   logic [9:0] fcnt = '0;
   logic [9:0] flen_exp = '0;
   logic [7:0] pend_exp = '0;
   logic       pend_use = 1'b0;
   logic       chk_lat = 1'b0;
   logic       rand_ready = 1'b0;

   // Reference: floor((g * y * (1-y) * 2^12 + 2^11) / 2^12) with y clamped to 1.0.
   function automatic logic [7:0] model(logic [7:0] y, logic [7:0] g);
      int yc, gv, n, qv;
      yc = (y > 8'd64) ? 64 : int'(y);
      gv = int'($signed(g));
      n  = gv * yc * (64 - yc) + 2048;
      qv = n / 4096;
      if (n < 0 && (n % 4096) != 0) qv = qv - 1;
      return qv[7:0];
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic cycle(output logic acc);
      logic       ix, ox, stall, fd_next;
      logic [7:0] pg;
      logic       pl;
      item_t      it;
      if (rand_ready) out_ready = 1'($urandom_range(0, 1));
      #1;
      ix      = in_valid && in_ready;
      ox      = out_valid && out_ready;
      stall   = out_valid && !out_ready;
      pg      = out_grad;
      pl      = out_last;
      fd_next = 1'b0;
      check("in_ready", 32'(in_ready), 32'(!(exp_q.size() == 3 && !out_ready)));
      if (ox) begin
         if (exp_q.size() == 0) begin
            check("spurious_out", 32'd1, 32'd0);
         end else begin
            it = exp_q.pop_front();
            check("out_grad", 32'(out_grad), 32'(it.g));
            check("out_last", 32'(out_last), 32'(it.l));
            if (chk_lat) check("latency", 32'(edge_n + 1 - it.e), 32'd3);
         end
         if (out_last) begin
            fd_next  = 1'b1;
            flen_exp = fcnt + 10'd1;
            fcnt     = '0;
         end else begin
            fcnt = fcnt + 10'd1;
         end
      end
      if (ix) begin
         it.g = pend_use ? pend_exp : model(in_y, in_grad);
         it.l = in_last;
         it.e = edge_n + 1;
         exp_q.push_back(it);
      end
      @(posedge clk);
      edge_n++;
      #1;
      check("frame_done", 32'(frame_done), 32'(fd_next));
      check("frame_len", 32'(frame_len), 32'(flen_exp));
      if (fd_next) fd_seen++;
      if (stall) begin
         check("stall_valid", 32'(out_valid), 32'd1);
         check("stall_grad", 32'(out_grad), 32'(pg));
         check("stall_last", 32'(out_last), 32'(pl));
      end
      acc = ix;
   endtask

   task automatic send(input logic [7:0] y, input logic [7:0] g, input logic l,
                       input logic use_exp, input logic [7:0] exp);
      logic a;
      int   b;
      in_valid = 1'b1;
      in_y     = y;
      in_grad  = g;
      in_last  = l;
      pend_use = use_exp;
      pend_exp = exp;
      b = 0;
      do begin
         cycle(a);
         b++;
      end while (!a && b < 50);
      if (!a) check("send_timeout", 32'd0, 32'd1);
   endtask

   task automatic drain();
      logic a;
      int   b;
      in_valid   = 1'b0;
      rand_ready = 1'b0;
      out_ready  = 1'b1;
      b = 0;
      while (exp_q.size() > 0 && b < 20) begin
         cycle(a);
         b++;
      end
      check("drain_empty", 32'(exp_q.size()), 32'd0);
      cycle(a);
   endtask

   initial begin
      logic a;
      int   fd0;

      // Reset state
      #12;
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_out_grad", 32'(out_grad), 32'd0);
      check("rst_out_last", 32'(out_last), 32'd0);
      check("rst_frame_done", 32'(frame_done), 32'd0);
      check("rst_frame_len", 32'(frame_len), 32'd0);
      check("rst_in_ready", 32'(in_ready), 32'd1);
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // Directed values, back-to-back, latency checked
      out_ready = 1'b1;
      chk_lat   = 1'b1;
      send(8'd32, 8'd100, 1'b0, 1'b1, 8'd25);
      send(8'd32, 8'h80,  1'b0, 1'b1, 8'hE0);
      send(8'd32, 8'd2,   1'b0, 1'b1, 8'd1);
      send(8'd32, 8'hFD,  1'b0, 1'b1, 8'hFF);
      send(8'd0,  8'd127, 1'b0, 1'b1, 8'd0);
      send(8'd64, 8'd127, 1'b0, 1'b1, 8'd0);
      send(8'd70, 8'd127, 1'b0, 1'b1, 8'd0);
      send(8'd16, 8'd64,  1'b1, 1'b1, 8'd12);
      drain();

      // Gapped input: one sample every third cycle
      for (int i = 0; i < 6; i++) begin
         send(8'($urandom_range(0, 255)), 8'($urandom), i == 5, 1'b0, 8'd0);
         in_valid = 1'b0;
         cycle(a);
         cycle(a);
      end
      drain();

      // Random backpressure streaming
      chk_lat    = 1'b0;
      rand_ready = 1'b1;
      for (int i = 0; i < 20; i++)
         send(8'($urandom_range(0, 255)), 8'($urandom), i == 19, 1'b0, 8'd0);
      drain();

      // Back-to-back frames of 1, 5, 5
      fd0 = fd_seen;
      for (int i = 0; i < 11; i++)
         send(8'($urandom_range(0, 80)), 8'($urandom), (i == 0 || i == 5 || i == 10), 1'b0, 8'd0);
      drain();
      check("frame_pulses", 32'(fd_seen - fd0), 32'd3);

      // Async reset with three samples in flight and cnt = 3
      for (int i = 0; i < 3; i++)
         send(8'($urandom_range(0, 64)), 8'($urandom), 1'b0, 1'b0, 8'd0);
      drain();
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++)
         send(8'($urandom_range(0, 64)), 8'($urandom), 1'b0, 1'b0, 8'd0);
      in_valid = 1'b0;
      check("full_out_valid", 32'(out_valid), 32'd1);
      check("full_in_ready", 32'(in_ready), 32'd0);
      rst_n = 1'b0;
      #1;
      check("arst_out_valid", 32'(out_valid), 32'd0);
      check("arst_frame_done", 32'(frame_done), 32'd0);
      check("arst_frame_len", 32'(frame_len), 32'd0);
      check("arst_in_ready", 32'(in_ready), 32'd1);
      exp_q.delete();
      fcnt     = '0;
      flen_exp = '0;
      @(posedge clk);
      @(posedge clk);
      #1;
      rst_n     = 1'b1;
      out_ready = 1'b1;
      send(8'd40, 8'd50, 1'b0, 1'b0, 8'd0);
      send(8'd20, 8'hC0, 1'b1, 1'b0, 8'd0);
      drain();
      check("post_rst_len", 32'(frame_len), 32'd2);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
